seq_int_alu: RTL and testbench
==============================

# seq_int_alu

Parametrised multi-cycle integer ALU executing the integer opcodes of the CPU datapath (add, subtract, unsigned/signed multiply, compare) at configurable width W, adding unsigned divide and a valid/ready handshake on both sides. Single-cycle ops retire in one cycle; multiply and divide iterate one bit per cycle, replacing the combinational CSA multiplier tree. Sits between the decode stage (operand/opcode source) and the writeback stage (result sink).

## Interface

- W, 8, operand width; legal range 4..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept; high only in IDLE
- op  input  3  opcode: 001 add, 010 sub, 011 umul, 100 smul, 101 udiv, 111 cmp; 000/110 illegal
- a  input  W  operand A
- b  input  W  operand B
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- result  output  2W  result
- ovf  output  1  overflow/carry flag
- zero  output  1  result == 0
- err  output  1  illegal opcode or divide by zero
- out_op  output  3  opcode of the retiring result

## Operation

- States: IDLE, BUSY, DONE. Accept when in_valid && in_ready; a, b, op are captured in the accept cycle.
- IDLE -> DONE for add, sub, cmp, illegal; IDLE -> BUSY for umul, smul, udiv (iteration counter loaded with W).
- BUSY: one radix-2 step per cycle; counter decrements; BUSY -> DONE when the final step is written.
- DONE: out_valid=1; result/flags/out_op held stable until out_valid && out_ready, then -> IDLE. No accept in DONE.
- add: result = zero-extended (a+b) mod 2^W; ovf = carry out of bit W-1.
- sub: result = zero-extended (a-b) mod 2^W; ovf = borrow (a < b unsigned).
- umul: result = a*b, 2W bits; ovf = |result[2W-1:W].
- smul: operands converted to magnitudes at accept; unsigned shift-add; product negated on the final step if sign(a)^sign(b); result = 2W-bit two's complement; ovf = 1 when result is not representable in W signed bits (result[2W-1:W-1] not all equal).
- udiv: restoring division; result[W-1:0] = quotient, result[2W-1:W] = remainder; ovf=0.
- udiv with b==0: no iteration; IDLE -> DONE; quotient = all ones, remainder = a, err=1.
- cmp: result[W-1:0] = {W{a!=b}}, upper W bits 0; ovf=0.
- illegal op: result=0, ovf=0, err=1, zero=1.
- zero is derived from the registered result.

## Timing

- Reset (async, rst_n low): state IDLE, in_ready=1 after release, out_valid=0, result=0, ovf=0, zero=0, err=0, out_op=000. Any in-flight operation is discarded; no partial result appears.
- Latency (accept edge to first cycle with out_valid=1): 1 cycle for add/sub/cmp/illegal/divide-by-zero; W+1 cycles for umul/smul/udiv.
- in_ready is a registered state decode; it falls in the cycle after accept and rises in the cycle after the result is retired.
- Throughput: one operation per (latency + 1) cycles with out_ready held high.
- in_valid while in_ready=0 is ignored; inputs need not stay stable after accept.
- out_ready without out_valid has no effect.
- Counter width is clog2(W)+1; no wrap-around occurs within a legal W.

## Test plan

- W=8, add a=0xF0, b=0x20 -> result=0x0010, ovf=1, zero=0; out_valid 1 cycle after accept. sub a=0x05, b=0x05 -> result=0, zero=1, ovf=0.
- umul a=0xFF, b=0xFF -> result=0xFE01, ovf=1; out_valid exactly 9 cycles after accept; in_ready low throughout.
- smul a=0xFD, b=0x04 -> result=0xFFF4, ovf=0. smul a=0x80, b=0xFF -> result=0x0080, ovf=1.
- udiv a=200, b=7 -> result=0x041C, err=0, latency 9. udiv a=0x55, b=0 -> result=0x55FF, err=1, latency 1. op=110 -> result=0, err=1, zero=1.
- Backpressure: complete umul with out_ready low for 5 cycles; result/flags/out_op stable and in_ready=0; in_valid pulses during this window are ignored; retire, then next add completes correctly.
- Assert rst_n low in the 4th BUSY cycle of udiv: out_valid=0 and all outputs zero immediately; after release in_ready=1, and a new cmp a=0x12, b=0x13 -> result=0x00FF.

Source files
------------

// File: rtl/seq_int_alu_if.sv
// seq_int_alu_if: valid/ready operand and result bus between decode, ALU and writeback
// Signals: in_valid/in_ready/op/a/b form the operand channel (decode -> ALU);
//          out_valid/out_ready/result/ovf/zero/err/out_op form the result channel (ALU -> writeback).
// Modports: slave for the ALU, master for the side that drives operands and sinks results.
interface seq_int_alu_if #(parameter int W = 8) ();
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           ovf;
    logic           zero;
    logic           err;
    logic [2:0]     out_op;
    modport slave  (input  in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, result, ovf, zero, err, out_op);
    modport master (output in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, result, ovf, zero, err, out_op);
endinterface

// File: rtl/seq_int_alu.sv
// seq_int_alu: multi-cycle integer ALU (add, sub, umul, smul, udiv, cmp) with valid/ready on both sides
// Ports: clk   - rising-edge clock
//        rst_n - asynchronous active-low reset
//        bus   - seq_int_alu_if.slave: operands/opcode in (in_valid/in_ready/op/a/b),
//                result out (out_valid/out_ready/result/ovf/zero/err/out_op)
module seq_int_alu #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    seq_int_alu_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_UMUL = 3'b011;
    localparam logic [2:0] OP_SMUL = 3'b100, OP_UDIV = 3'b101, OP_CMP = 3'b111;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hi, r_lo, r_opd;
    logic           r_neg, r_ovf, r_err;
    logic [2:0]     r_op;
    logic [2*W-1:0] r_result;
    logic           w_acc, w_last, w_multi, w_ill, w_ovf1, w_ge, w_fovf;
    logic [W:0]     w_add, w_sub, w_sum, w_sh, w_dif;
    logic [W-1:0]   w_abs_a, w_abs_b, w_nhi, w_nlo;
    logic [2*W-1:0] w_res1, w_prod, w_fin;

    assign w_acc  = bus.in_valid && r_state == IDLE;
    assign w_last = r_cnt == CW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (w_multi ? BUSY : DONE) : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            default: w_next = bus.out_ready ? IDLE : DONE;
        endcase
    end

    // Single-cycle results, flags and iteration setup, all taken from the accept-cycle inputs
    always_comb begin
        w_add   = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub   = {1'b0, bus.a} - {1'b0, bus.b};
        w_ill   = !(bus.op inside {OP_ADD, OP_SUB, OP_UMUL, OP_SMUL, OP_UDIV, OP_CMP});
        w_multi = bus.op == OP_UMUL || bus.op == OP_SMUL || (bus.op == OP_UDIV && bus.b != '0);
        w_res1  = bus.op == OP_ADD ? {{W{1'b0}}, w_add[W-1:0]} :
                  bus.op == OP_SUB ? {{W{1'b0}}, w_sub[W-1:0]} :
                  bus.op == OP_CMP ? {{W{1'b0}}, {W{bus.a != bus.b}}} :
                  (bus.op == OP_UDIV && bus.b == '0) ? {bus.a, {W{1'b1}}} : '0;
        w_ovf1  = bus.op == OP_ADD ? w_add[W] : bus.op == OP_SUB ? w_sub[W] : 1'b0;
        w_abs_a = bus.a[W-1] ? -bus.a : bus.a;
        w_abs_b = bus.b[W-1] ? -bus.b : bus.b;
    end

    // One radix-2 step on {r_hi, r_lo}: shift-add for multiply, restoring subtract for divide.
    // Both leave {high half, low half} = {product hi, lo} or {remainder, quotient}.
    always_comb begin
        w_sum  = {1'b0, r_hi} + {1'b0, r_lo[0] ? r_opd : {W{1'b0}}};
        w_sh   = {r_hi, r_lo[W-1]};
        w_dif  = w_sh - {1'b0, r_opd};
        w_ge   = w_sh >= {1'b0, r_opd};
        w_nhi  = r_op == OP_UDIV ? (w_ge ? w_dif[W-1:0] : w_sh[W-1:0]) : w_sum[W:1];
        w_nlo  = r_op == OP_UDIV ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};
        w_prod = {w_nhi, w_nlo};
        w_fin  = (r_op == OP_SMUL && r_neg) ? -w_prod : w_prod;
        w_fovf = r_op == OP_UMUL ? |w_fin[2*W-1:W] :
                 r_op == OP_SMUL ? !(&w_fin[2*W-1:W-1] || !(|w_fin[2*W-1:W-1])) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_op     <= '0;
            r_result <= '0;
        end else if (w_acc) begin
            r_cnt    <= CW'(W);
            r_hi     <= '0;
            r_lo     <= bus.op == OP_SMUL ? w_abs_b : bus.op == OP_UDIV ? bus.a : bus.b;
            r_opd    <= bus.op == OP_SMUL ? w_abs_a : bus.op == OP_UDIV ? bus.b : bus.a;
            r_neg    <= bus.a[W-1] ^ bus.b[W-1];
            r_ovf    <= w_ovf1;
            r_err    <= w_ill || (bus.op == OP_UDIV && bus.b == '0);
            r_op     <= bus.op;
            r_result <= w_res1;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            if (w_last) begin
                r_result <= w_fin;
                r_ovf    <= w_fovf;
            end
        end

    always_comb begin
        bus.in_ready  = r_state == IDLE;
        bus.out_valid = r_state == DONE;
        bus.zero      = r_state == DONE && r_result == '0;
    end

    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.err    = r_err;
    assign bus.out_op = r_op;
endmodule

// File: tb/tb_seq_int_alu.sv
// tb_seq_int_alu: directed and random scoreboard checks of seq_int_alu at W=8
module tb_seq_int_alu;
    localparam int W = 8;
    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        logic        err;
        logic [2:0]  op;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_int_alu_if #(.W(W)) bus ();
    seq_int_alu #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [15:0] r, input logic o, input logic z, input logic e,
                        input logic [2:0] op, input int lat);
        exp_t x;
        x.res = r; x.ovf = o; x.zero = z; x.err = e; x.op = op; x.lat = lat;
        sb.push_back(x);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int s, sx, sy;
        e.res = '0; e.ovf = 1'b0; e.err = 1'b0; e.op = o; e.lat = 1;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'b001: begin s = int'(x) + int'(y); e.res = 16'(s % 256); e.ovf = s > 255; end
            3'b010: begin e.res = 16'((int'(x) - int'(y) + 256) % 256); e.ovf = x < y; end
            3'b011: begin s = int'(x) * int'(y); e.res = 16'(s); e.ovf = s > 255; e.lat = 9; end
            3'b100: begin s = sx * sy; e.res = 16'(s); e.ovf = s > 127 || s < -128; e.lat = 9; end
            3'b101: if (y == 0) begin e.res = {x, 8'hFF}; e.err = 1'b1; end
                    else begin e.res = {8'(x % y), 8'(x / y)}; e.lat = 9; end
            3'b111: e.res = (x != y) ? 16'h00FF : 16'h0000;
            default: e.err = 1'b1;
        endcase
        e.zero = e.res == 16'h0000;
        return e;
    endfunction

    // Called at a negedge; returns just after the accept edge with inputs scrambled.
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
    endtask

    // Waits for the result, checks latency and contents, holds it for 'hold' cycles, then retires it.
    task automatic get(input int hold);
        int lat = 1;
        exp_t e;
        logic [15:0] r0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            chk("in_ready_busy", 32'(bus.in_ready), 0);
            @(negedge clk);
            lat++;
        end
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard: got 0 entries want at least 1");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("result", 32'(bus.result), 32'(e.res));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("zero", 32'(bus.zero), 32'(e.zero));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("out_op", 32'(bus.out_op), 32'(e.op));
        chk("in_ready_done", 32'(bus.in_ready), 0);
        r0 = bus.result;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~i[0];
            bus.op = 3'b001; bus.a = 8'h01; bus.b = 8'h01;
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_result", 32'(bus.result), 32'(r0));
            chk("hold_ovf", 32'(bus.ovf), 32'(e.ovf));
            chk("hold_op", 32'(bus.out_op), 32'(e.op));
            chk("hold_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("retired_valid", 32'(bus.out_valid), 0);
        chk("retired_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        exp_t e;
        logic [2:0] o;
        logic [7:0] x, y;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_zero", 32'(bus.zero), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_op", 32'(bus.out_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("spurious_out_ready", 32'(bus.out_valid), 0);
        push(16'h0010, 1'b1, 1'b0, 1'b0, 3'b001, 1); send(3'b001, 8'hF0, 8'h20); get(0);
        push(16'h0000, 1'b0, 1'b1, 1'b0, 3'b010, 1); send(3'b010, 8'h05, 8'h05); get(0);
        push(16'hFE01, 1'b1, 1'b0, 1'b0, 3'b011, 9); send(3'b011, 8'hFF, 8'hFF); get(5);
        push(16'h0046, 1'b0, 1'b0, 1'b0, 3'b001, 1); send(3'b001, 8'h12, 8'h34); get(0);
        push(16'hFFF4, 1'b0, 1'b0, 1'b0, 3'b100, 9); send(3'b100, 8'hFD, 8'h04); get(0);
        push(16'h0080, 1'b1, 1'b0, 1'b0, 3'b100, 9); send(3'b100, 8'h80, 8'hFF); get(0);
        push(16'h041C, 1'b0, 1'b0, 1'b0, 3'b101, 9); send(3'b101, 8'd200, 8'd7); get(0);
        push(16'h55FF, 1'b0, 1'b0, 1'b1, 3'b101, 1); send(3'b101, 8'h55, 8'h00); get(0);
        push(16'h0000, 1'b0, 1'b1, 1'b1, 3'b110, 1); send(3'b110, 8'h37, 8'h21); get(0);
        push(16'h0000, 1'b0, 1'b1, 1'b1, 3'b000, 1); send(3'b000, 8'hAA, 8'h55); get(0);
        push(16'h0000, 1'b0, 1'b1, 1'b0, 3'b111, 1); send(3'b111, 8'h3C, 8'h3C); get(0);
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = (i % 5 == 4) ? 8'h00 : 8'($urandom);
            e = model(o, x, y);
            sb.push_back(e);
            send(o, x, y);
            get(i % 3);
        end
        send(3'b101, 8'd200, 8'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_result", 32'(bus.result), 0);
        chk("mid_rst_ovf", 32'(bus.ovf), 0);
        chk("mid_rst_zero", 32'(bus.zero), 0);
        chk("mid_rst_err", 32'(bus.err), 0);
        chk("mid_rst_op", 32'(bus.out_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.out_valid), 0);
            chk("post_rst_ready", 32'(bus.in_ready), 1);
        end
        push(16'h00FF, 1'b0, 1'b0, 1'b0, 3'b111, 1); send(3'b111, 8'h12, 8'h13); get(0);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
